cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single SDRAM controller port between the instruction-cache refill engine and the data-cache refill/write-back engine. It sits between the two cache controllers and the SDRAM controller. It is the block whose grants turn into the `d_cache_read_miss` and `d_cache_write_miss` stall durations seen by the CPU hazard logic. Arbitration is data-priority with an anti-starvation counter for instruction refills. Address, write data and write enable are multiplexed toward memory, and per-word strobes are steered back to the granted requester.

## Interface
Parameters:
- `ADDR_W`, 24: word address width.
- `DATA_W`, 16: data word width.
- `STARVE_MAX`, 2: number of consecutive D grants allowed while I is pending (1..7).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `i_req`, in, 1: I-cache line-read request. Held high until `i_done`.
- `i_addr`, in, ADDR_W: line base address. Stable while `i_req` is high.
- `i_rvalid`, out, 1: word strobe to the I-cache. Qualifies `mem_rdata`.
- `i_done`, out, 1: one-cycle pulse at the end of the I transaction.
- `d_req`, in, 1: D-cache transaction request. Held high until `d_done`.
- `d_wren`, in, 1: 1 means line write-back, 0 means line read. Stable with `d_req`.
- `d_addr`, in, ADDR_W: line base address.
- `d_wdata`, in, DATA_W: current write word, supplied by the D-cache.
- `d_rvalid`, out, 1: read word strobe to the D-cache.
- `d_wnext`, out, 1: write word consumed. The D-cache advances `d_wdata` on the next cycle.
- `d_done`, out, 1: one-cycle pulse at the end of the D transaction.
- `mem_req`, out, 1: request to the SDRAM controller.
- `mem_wren`, out, 1: write transaction.
- `mem_addr`, out, ADDR_W: transaction address.
- `mem_wdata`, out, DATA_W: write word.
- `mem_ack`, in, 1: controller accepted the request.
- `mem_rvalid`, in, 1: read word valid on `mem_rdata`.
- `mem_wnext`, in, 1: write word consumed.
- `mem_done`, in, 1: transaction complete.
- `mem_rdata`, in, DATA_W: broadcast unmodified to both caches. The arbiter does not register it.
- `busy`, out, 1: arbiter is not in IDLE. Debug/perf output.

## Operation
- FSM states: IDLE, REQ_I, XFER_I, REQ_D, XFER_D.
- **IDLE, arbitration.** Arbitration happens only in IDLE.
  - Only `i_req` high: go to REQ_I.
  - Only `d_req` high: go to REQ_D.
  - Both high: REQ_D, unless `starve_cnt == STARVE_MAX`, in which case REQ_I.
- **REQ_x.**
  - `mem_req`=1. `mem_addr`/`mem_wren` come from the granted side; `mem_wren` is forced to 0 for I.
  - On `mem_ack`, go to XFER_x. `mem_req` drops in the cycle after `mem_ack` is sampled.
- **XFER_x.**
  - `mem_rvalid` is steered combinationally to `x_rvalid`.
  - `mem_wnext` is steered to `d_wnext` (D only).
  - On `mem_done`: pulse `x_done` in the same cycle, then go to IDLE.
- **Output muxes.**
  - `mem_addr`, `mem_wren` and `mem_wdata` select the D side in REQ_D/XFER_D.
  - They select the I side in REQ_I/XFER_I.
  - In IDLE they are held at 0.
- **Steering rule.** Strobes for the non-granted side are always 0. Any memory strobe that arrives in IDLE or REQ_x is ignored.
- **`starve_cnt` (3 bits):**
  - Increments when a D grant is made while `i_req` is high.
  - Clears on any I grant.
  - Clears when a D grant is made with `i_req` low.
  - Saturates at STARVE_MAX.
- **Requester protocol.**
  - A requester must not drop `req` before its `done`.
  - Dropping it early is a protocol violation with undefined behaviour. It is flagged by a simulation-only assertion.
- **Reset.** On `rst`, go to IDLE and set `starve_cnt`=0. All outputs are 0 in the cycle after `rst` is sampled. Reset mid-transaction abandons the transfer. The SDRAM controller and caches are reset by the same `rst`.

## Timing
- **Grant latency.** A request sampled in IDLE at cycle N gives `mem_req`=1 at cycle N+1 (registered state).
- **`mem_ack` in the same cycle as `mem_req`.** Legal. XFER begins at N+2.
- **Turnaround.** `mem_done` at cycle M gives `x_done` at M and IDLE at M+1. The earliest next `mem_req` is M+2, so there is one dead cycle of turnaround.
- **Back-to-back `req`.** A requester may keep `req` high after `done` to request the next line. This is treated as a new request at M+1.
- **`mem_done` with a final `mem_rvalid`/`mem_wnext`.** Both are steered in the same cycle.
- **Read data.** `mem_rdata` has zero latency through the block. `x_rvalid` is combinational from `mem_rvalid` and registered state only.
- **Reset values.** `mem_req`, `mem_wren`, `mem_addr`, `mem_wdata`, all strobes, all `done` outputs and `busy` are 0.

## Structure
- Shared package `neonfox_mem_pkg`:
  - Typedef `arb_state_t` for the five states.
  - `localparam` defaults for ADDR_W and DATA_W, shared with the cache controllers and the SDRAM controller.
- Single module with no sub-modules. The FSM, the starvation counter and the output muxes are small enough to stay flat.

## Test plan
- **Single I read:** `i_req`=1 with `i_addr`=0x000100; controller acks immediately and issues 4 `mem_rvalid` then `mem_done`. Required: `mem_req` high for exactly 1 cycle, 4 `i_rvalid`, 1 `i_done`, all `d_*` strobes 0.
- **D write-back:** `d_req`=1, `d_wren`=1, `d_addr`=0x00ABC0; `mem_ack` delayed 3 cycles. Required: `mem_req` held 4 cycles, `mem_wren`=1, each `mem_wnext` mirrored on `d_wnext`, and `mem_wdata` tracks `d_wdata`.
- **Simultaneous requests:** `i_req` and `d_req` both held continuously with STARVE_MAX=2. Required grant order D, D, I, D, D, I, with one idle cycle between transactions.
- **Strobe isolation:** spurious `mem_rvalid` in IDLE and during REQ_I before ack. Required: no `i_rvalid` or `d_rvalid` is produced.
- **Reset mid-XFER_D:** `rst` pulsed after the 2nd `mem_rvalid`. Required: the next cycle has all outputs 0, `busy`=0 and `starve_cnt`=0. A following `i_req` is granted at N+1.

Source files
------------

// File: rtl/neonfox_mem_pkg.sv
// ----------------------------------------------------------------------------
// neonfox_mem_pkg
// Types and defaults shared by the cache controllers, the cache/memory arbiter
// and the SDRAM controller.
//   MEM_ADDR_W / MEM_DATA_W : default word-address and data widths
//   STARVE_W                : width of the arbiter's instruction-starvation counter
//   arb_state_t             : arbiter FSM states
//   starve_next()           : next value of the starvation counter on a D grant
// ----------------------------------------------------------------------------
package neonfox_mem_pkg;

    localparam int MEM_ADDR_W = 24;
    localparam int MEM_DATA_W = 16;
    localparam int STARVE_W   = 3;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_REQ_I  = 3'd1,
        ARB_XFER_I = 3'd2,
        ARB_REQ_D  = 3'd3,
        ARB_XFER_D = 3'd4
    } arb_state_t;

    // A D grant made while an I refill waits counts against the I side,
    // saturating at the limit; a D grant with nobody waiting clears the count.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] limit,
        input logic                i_waiting
    );
        logic [STARVE_W-1:0] nxt;
        if (!i_waiting) begin
            nxt = 3'd0;
        end else if (cnt >= limit) begin
            nxt = limit;
        end else begin
            nxt = cnt + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_checker.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter_checker
// Simulation-only protocol monitor for the arbiter's requester side: once a
// requester raises req it must hold it until the arbiter returns its done.
// Ports: clk, rst, i_req, i_done, d_req, d_done (all observed, no outputs).
// ----------------------------------------------------------------------------
module cache_mem_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic i_req,
    input logic i_done,
    input logic d_req,
    input logic d_done
);

    logic i_owed;
    logic d_owed;

    // Remember which requesters were mid-request (req high, no done) last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_owed <= 1'b0;
            d_owed <= 1'b0;
        end else begin
            i_owed <= i_req & ~i_done;
            d_owed <= d_req & ~d_done;
        end
    end

    // Flag a requester that let go of req before its done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!i_owed || i_req) else $error("i_req dropped before i_done");
            assert (!d_owed || d_req) else $error("d_req dropped before d_done");
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single SDRAM controller port between the I-cache refill engine
// and the D-cache refill/write-back engine. D has priority; an I refill that
// has been passed over STARVE_MAX times in a row wins the next arbitration.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_req, i_addr                  : I-cache line read request
//   i_rvalid, i_done               : read word strobe / end of I transaction
//   d_req, d_wren, d_addr, d_wdata : D-cache line read or write-back request
//   d_rvalid, d_wnext, d_done      : read strobe / write word consumed / end
//   mem_req, mem_wren, mem_addr, mem_wdata : request toward SDRAM controller
//   mem_ack, mem_rvalid, mem_wnext, mem_done, mem_rdata : controller replies
//   busy                           : arbiter not idle (debug/perf)
// mem_rdata is wired straight to both caches outside this block.
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import neonfox_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wren,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic              d_wnext,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic              mem_wnext,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic                grant_i;
    logic                grant_d;
    logic                xfer_i;
    logic                xfer_d;
    logic                d_side;
    logic                unused_rdata;

    // Arbitration decision, only acted upon while the FSM is idle.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (starve_cnt == STARVE_LIM) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (i_req) begin
            grant_i = 1'b1;
        end else if (d_req) begin
            grant_d = 1'b1;
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Arbiter FSM with the starvation counter and registered request outputs.
    // Address and write enable are captured at grant time; the requester holds
    // them stable until done, so the captured copy equals the live input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            starve_cnt <= 3'd0;
            mem_req    <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state      <= ARB_REQ_I;
                        starve_cnt <= 3'd0;
                        mem_req    <= 1'b1;
                        mem_wren   <= 1'b0;
                        mem_addr   <= i_addr;
                        busy       <= 1'b1;
                    end else if (grant_d) begin
                        state      <= ARB_REQ_D;
                        starve_cnt <= starve_next(starve_cnt, STARVE_LIM, i_req);
                        mem_req    <= 1'b1;
                        mem_wren   <= d_wren;
                        mem_addr   <= d_addr;
                        busy       <= 1'b1;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_REQ_I: begin
                    if (mem_ack) begin
                        state   <= ARB_XFER_I;
                        mem_req <= 1'b0;
                    end else begin
                        state <= ARB_REQ_I;
                    end
                end
                ARB_REQ_D: begin
                    if (mem_ack) begin
                        state   <= ARB_XFER_D;
                        mem_req <= 1'b0;
                    end else begin
                        state <= ARB_REQ_D;
                    end
                end
                ARB_XFER_I, ARB_XFER_D: begin
                    if (mem_done) begin
                        state    <= ARB_IDLE;
                        mem_wren <= 1'b0;
                        mem_addr <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state <= state;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    starve_cnt <= 3'd0;
                    mem_req    <= 1'b0;
                    mem_wren   <= 1'b0;
                    mem_addr   <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Strobes pass through only in the granted side's XFER state, so anything
    // the controller raises while idle or still requesting is dropped.
    assign xfer_i   = (state == ARB_XFER_I);
    assign xfer_d   = (state == ARB_XFER_D);
    assign d_side   = (state == ARB_REQ_D) || (state == ARB_XFER_D);

    assign i_rvalid = xfer_i & mem_rvalid;
    assign i_done   = xfer_i & mem_done;
    assign d_rvalid = xfer_d & mem_rvalid;
    assign d_wnext  = xfer_d & mem_wnext;
    assign d_done   = xfer_d & mem_done;

    // Write data is live from the D-cache so it follows each d_wnext advance.
    assign mem_wdata = d_side ? d_wdata : '0;

    // Read data reaches the caches directly; referenced here only to tie the port.
    assign unused_rdata = ^mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Self-checking bench: expected grants go into a scoreboard queue when a
// request is raised and are popped when mem_req rises. Every cycle the output
// muxes are checked against the scoreboard entry currently owning the port.
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
    import neonfox_mem_pkg::*;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 2;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              i_req      = 1'b0;
    logic [ADDR_W-1:0] i_addr     = '0;
    logic              i_rvalid;
    logic              i_done;
    logic              d_req      = 1'b0;
    logic              d_wren     = 1'b0;
    logic [ADDR_W-1:0] d_addr     = '0;
    logic [DATA_W-1:0] d_wdata    = '0;
    logic              d_rvalid;
    logic              d_wnext;
    logic              d_done;
    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack    = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic              mem_wnext  = 1'b0;
    logic              mem_done   = 1'b0;
    logic [DATA_W-1:0] mem_rdata  = '0;
    logic              busy;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_wnext(d_wnext), .d_done(d_done),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_wnext(mem_wnext),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
    );

    cache_mem_arbiter_checker u_chk (
        .clk(clk), .rst(rst), .i_req(i_req), .i_done(i_done), .d_req(d_req), .d_done(d_done)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wren;
        int                side;   // 1 = I, 2 = D
    } grant_t;

    grant_t            exp_grants[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                n_req_cyc, n_irv, n_drv, n_dwn, n_idone, n_ddone;
    logic              prev_req = 1'b0;
    int                cur_side = 0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic              cur_wren = 1'b0;

    task automatic clear_counts();
        n_req_cyc = 0; n_irv = 0; n_drv = 0; n_dwn = 0; n_idone = 0; n_ddone = 0;
    endtask

    task automatic push_grant(input logic [ADDR_W-1:0] addr, input logic wren, input int side);
        grant_t g;
        g.addr = addr; g.wren = wren; g.side = side;
        exp_grants.push_back(g);
    endtask

    // One clock: sample at negedge, pop scoreboard on a new grant, check muxes,
    // then advance past the rising edge and model the D-cache/owner bookkeeping.
    task automatic cycle();
        grant_t            g;
        logic [ADDR_W-1:0] e_addr;
        logic              e_wren;
        logic [DATA_W-1:0] e_wdata;
        logic              e_busy;
        logic              adv;
        logic              release_port;
        @(negedge clk);
        if (mem_req === 1'b1 && prev_req !== 1'b1) begin
            n_cmp++;
            if (exp_grants.size() == 0) begin
                n_bad++;
                $display("FAIL grant_unexpected addr=%h required no grant", mem_addr);
            end else begin
                g = exp_grants.pop_front();
                cur_side = g.side; cur_addr = g.addr; cur_wren = g.wren;
            end
        end
        e_addr  = (cur_side != 0) ? cur_addr : '0;
        e_wren  = (cur_side == 2) ? cur_wren : 1'b0;
        e_wdata = (cur_side == 2) ? d_wdata : '0;
        e_busy  = (cur_side != 0);
        n_cmp++;
        if (mem_addr !== e_addr || mem_wren !== e_wren || mem_wdata !== e_wdata || busy !== e_busy) begin
            n_bad++;
            $display("FAIL mux_out t=%0t addr=%h/%h wren=%b/%b wdata=%h/%h busy=%b/%b (actual/required)",
                     $time, mem_addr, e_addr, mem_wren, e_wren, mem_wdata, e_wdata, busy, e_busy);
        end
        n_req_cyc += int'(mem_req);
        n_irv     += int'(i_rvalid);
        n_drv     += int'(d_rvalid);
        n_dwn     += int'(d_wnext);
        n_idone   += int'(i_done);
        n_ddone   += int'(d_done);
        prev_req     = mem_req;
        adv          = d_wnext;
        release_port = i_done | d_done | rst;
        @(posedge clk);
        #1;
        if (adv) d_wdata = d_wdata + 16'd1;
        if (release_port) cur_side = 0;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (mem_req !== 1'b1 && waited < 40) begin
            cycle();
            waited++;
        end
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL req_timeout mem_req=%b required 1 within 40 cycles", mem_req);
        end
    endtask

    // SDRAM controller model: ack after ack_dly cycles, then nwords strobes.
    task automatic serve(input int ack_dly, input int nwords, input bit wr,
                         input bit done_last, input bit spur, output int waited);
        wait_req(waited);
        if (mem_req === 1'b1) begin
            for (int k = 0; k < ack_dly; k++) begin
                mem_rvalid = spur;
                cycle();
            end
            mem_rvalid = 1'b0;
            mem_ack = 1'b1;
            cycle();
            mem_ack = 1'b0;
            for (int k = 0; k < nwords; k++) begin
                mem_rvalid = !wr;
                mem_wnext  = wr;
                mem_rdata  = 16'(k);
                mem_done   = done_last && (k == nwords - 1);
                cycle();
            end
            mem_rvalid = 1'b0;
            mem_wnext  = 1'b0;
            if (!done_last) begin
                mem_done = 1'b1;
                cycle();
            end
            mem_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_cmp++;
        if ({mem_req, mem_wren, mem_addr, mem_wdata, i_rvalid, i_done,
             d_rvalid, d_wnext, d_done, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs req=%b addr=%h busy=%b required all 0", mem_req, mem_addr, busy);
        end
        cycle();
    endtask

    task automatic test_single_i_read();
        int w;
        clear_counts();
        d_wren = 1'b1;              // must not leak onto mem_wren for an I grant
        i_addr = 24'h000100;
        i_req  = 1'b1;
        push_grant(24'h000100, 1'b0, 1);
        serve(0, 4, 1'b0, 1'b0, 1'b0, w);
        i_req  = 1'b0;
        d_wren = 1'b0;
        cycle();
        n_cmp++; if (w != 1)         begin n_bad++; $display("FAIL i_grant_latency %0d required 1", w); end
        n_cmp++; if (n_req_cyc != 1) begin n_bad++; $display("FAIL i_req_cycles %0d required 1", n_req_cyc); end
        n_cmp++; if (n_irv != 4)     begin n_bad++; $display("FAIL i_rvalid_count %0d required 4", n_irv); end
        n_cmp++; if (n_idone != 1)   begin n_bad++; $display("FAIL i_done_count %0d required 1", n_idone); end
        n_cmp++; if (n_drv + n_dwn + n_ddone != 0) begin
            n_bad++; $display("FAIL i_read_d_strobes %0d required 0", n_drv + n_dwn + n_ddone);
        end
    endtask

    task automatic test_d_writeback();
        int w;
        clear_counts();
        d_wren  = 1'b1;
        d_addr  = 24'h00ABC0;
        d_wdata = 16'hA000;
        d_req   = 1'b1;
        push_grant(24'h00ABC0, 1'b1, 2);
        serve(3, 4, 1'b1, 1'b1, 1'b0, w);
        d_req = 1'b0;
        cycle();
        n_cmp++; if (n_req_cyc != 4) begin n_bad++; $display("FAIL d_req_cycles %0d required 4", n_req_cyc); end
        n_cmp++; if (n_dwn != 4)     begin n_bad++; $display("FAIL d_wnext_count %0d required 4", n_dwn); end
        n_cmp++; if (n_ddone != 1)   begin n_bad++; $display("FAIL d_done_count %0d required 1", n_ddone); end
        n_cmp++; if (d_wdata !== 16'hA004) begin n_bad++; $display("FAIL d_wdata_advance %h required a004", d_wdata); end
        n_cmp++; if (n_drv + n_irv + n_idone != 0) begin
            n_bad++; $display("FAIL wb_other_strobes %0d required 0", n_drv + n_irv + n_idone);
        end
    endtask

    task automatic test_simultaneous();
        int w;
        clear_counts();
        i_addr = 24'h000100;
        d_addr = 24'h002000;
        d_wren = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        // D, D, I, D, D, I while both wait, then a final D once I has let go
        for (int k = 0; k < 7; k++) begin
            if (k == 2 || k == 5) push_grant(24'h000100, 1'b0, 1);
            else                  push_grant(24'h002000, 1'b0, 2);
        end
        for (int k = 0; k < 7; k++) begin
            serve(0, 2, 1'b0, 1'b1, 1'b0, w);
            n_cmp++;
            if (w != 1) begin n_bad++; $display("FAIL turnaround grant %0d waited %0d required 1", k, w); end
            if (k == 5) i_req = 1'b0;
            if (k == 6) d_req = 1'b0;
        end
        cycle();
        n_cmp++; if (exp_grants.size() != 0) begin n_bad++; $display("FAIL sim_grants_left %0d required 0", exp_grants.size()); end
        n_cmp++; if (n_idone != 2) begin n_bad++; $display("FAIL sim_i_done %0d required 2", n_idone); end
        n_cmp++; if (n_ddone != 5) begin n_bad++; $display("FAIL sim_d_done %0d required 5", n_ddone); end
        n_cmp++; if (n_irv != 4 || n_drv != 10) begin
            n_bad++; $display("FAIL sim_rvalid i=%0d d=%0d required 4 and 10", n_irv, n_drv);
        end
    endtask

    task automatic test_strobe_isolation();
        int w;
        clear_counts();
        mem_rvalid = 1'b1;
        mem_wnext  = 1'b1;
        mem_done   = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        mem_wnext = 1'b0;
        mem_done  = 1'b0;
        i_addr = 24'h000180;
        i_req  = 1'b1;
        push_grant(24'h000180, 1'b0, 1);
        serve(2, 1, 1'b0, 1'b0, 1'b1, w);
        i_req = 1'b0;
        cycle();
        n_cmp++; if (n_irv != 1)   begin n_bad++; $display("FAIL iso_i_rvalid %0d required 1", n_irv); end
        n_cmp++; if (n_idone != 1) begin n_bad++; $display("FAIL iso_i_done %0d required 1", n_idone); end
        n_cmp++; if (n_drv + n_dwn + n_ddone != 0) begin
            n_bad++; $display("FAIL iso_d_strobes %0d required 0", n_drv + n_dwn + n_ddone);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int w;
        clear_counts();
        i_addr = 24'h000300;
        d_addr = 24'h004000;
        d_wren = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        push_grant(24'h004000, 1'b0, 2);
        wait_req(w);
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            cycle();
        end
        n_cmp++; if (dut.starve_cnt !== 3'd1) begin n_bad++; $display("FAIL starve_before_rst %0d required 1", dut.starve_cnt); end
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        cycle();
        rst = 1'b0;                 // mem_rvalid deliberately left high
        n_cmp++;
        if ({mem_req, mem_wren, mem_addr, mem_wdata, i_rvalid, i_done,
             d_rvalid, d_wnext, d_done, busy} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs req=%b drv=%b busy=%b required all 0", mem_req, d_rvalid, busy);
        end
        n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL starve_after_rst %0d required 0", dut.starve_cnt); end
        n_cmp++; if (n_drv != 3) begin n_bad++; $display("FAIL rst_mid_d_rvalid %0d required 3", n_drv); end
        mem_rvalid = 1'b0;
        i_req = 1'b1;
        push_grant(24'h000300, 1'b0, 1);
        cycle();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL post_rst_grant mem_req=%b required 1", mem_req); end
        serve(0, 1, 1'b0, 1'b1, 1'b0, w);
        i_req = 1'b0;
        cycle();
        n_cmp++; if (n_idone != 1) begin n_bad++; $display("FAIL post_rst_i_done %0d required 1", n_idone); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_single_i_read();
        test_d_writeback();
        test_simultaneous();
        test_strobe_isolation();
        test_reset_mid_xfer();
        n_cmp++;
        if (exp_grants.size() != 0) begin
            n_bad++;
            $display("FAIL grants_outstanding %0d required 0", exp_grants.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
